// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: FSM states,
// ALU/next-PC/register-select codes, instruction classes and opcode/funct values.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } aluop_e;

  typedef enum logic [3:0] {
    IC_NONE, IC_RTYPE, IC_ADDI, IC_ORI, IC_LW, IC_SW, IC_BEQ, IC_J, IC_JAL
  } iclass_e;

  localparam logic [SEL_W-1:0] NPC_PC4    = 2'b00;
  localparam logic [SEL_W-1:0] NPC_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] NPC_JUMP   = 2'b10;

  localparam logic [SEL_W-1:0] GPR_RD = 2'b00;
  localparam logic [SEL_W-1:0] GPR_RT = 2'b01;
  localparam logic [SEL_W-1:0] GPR_RA = 2'b10;

  localparam logic [SEL_W-1:0] WD_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WD_MEM = 2'b01;
  localparam logic [SEL_W-1:0] WD_PC  = 2'b10;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: Op/Funct to instruction class and ALU operation.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  output iclass_e         iclass,
  output aluop_e          aluop
);

  always_comb begin
    iclass = IC_NONE;
    aluop  = ALU_NOP;
    case (op)
      OP_RTYPE: begin
        iclass = IC_RTYPE;
        case (funct)
          FN_ADD, FN_ADDU: aluop = ALU_ADD;
          FN_SUB, FN_SUBU: aluop = ALU_SUB;
          FN_AND:          aluop = ALU_AND;
          FN_OR:           aluop = ALU_OR;
          FN_SLT:          aluop = ALU_SLT;
          FN_SLTU:         aluop = ALU_SLTU;
          FN_SLL:          aluop = ALU_SLL;
          default:         iclass = IC_NONE;
        endcase
      end
      OP_ADDI: begin iclass = IC_ADDI; aluop = ALU_ADD; end
      OP_ORI:  begin iclass = IC_ORI;  aluop = ALU_OR;  end
      OP_LW:   begin iclass = IC_LW;   aluop = ALU_ADD; end
      OP_SW:   begin iclass = IC_SW;   aluop = ALU_ADD; end
      OP_BEQ:  begin iclass = IC_BEQ;  aluop = ALU_SUB; end
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: IF/ID/EXE/MEM/WB FSM with Moore/Mealy control strobes.
// Optional MULTICYCLE_CTRL_TRAP_EN sends undecoded instructions to a sticky TRAP state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    Op,
  input  logic [OP_W-1:0]    Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               EXTOp,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [SEL_W-1:0]   NPCOp,
  output logic [SEL_W-1:0]   GPRSel,
  output logic [SEL_W-1:0]   WDSel,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  state_e  state_q, state_d;
  iclass_e iclass;
  aluop_e  dec_aluop;

  mc_decode u_decode (
    .op     (Op),
    .funct  (Funct),
    .iclass (iclass),
    .aluop  (dec_aluop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Strobes are held low while reset is asserted so an abandoned access never completes.
  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = '0;
    NPCOp    = NPC_PC4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            NPCOp   = NPC_PC4;
            state_d = S_ID;
          end
        end
        S_ID: begin
          case (iclass)
            IC_J: begin
              PCWrite = 1'b1;
              NPCOp   = NPC_JUMP;
              state_d = S_IF;
            end
            IC_JAL: begin
              PCWrite = 1'b1;
              NPCOp   = NPC_JUMP;
              state_d = S_WB;
            end
            IC_NONE: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
              state_d = S_TRAP;
`else
              state_d = S_IF;
`endif
            end
            default: state_d = S_EXE;
          endcase
        end
        S_EXE: begin
          ALUOp  = ALUOP_W'(dec_aluop);
          ALUSrc = (iclass inside {IC_ADDI, IC_ORI, IC_LW, IC_SW});
          EXTOp  = (iclass inside {IC_ADDI, IC_LW, IC_SW});
          if (iclass == IC_BEQ) begin
            PCWrite = Zero;
            NPCOp   = NPC_BRANCH;
            state_d = S_IF;
          end else if (iclass inside {IC_LW, IC_SW}) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          if (iclass == IC_LW) MemRead  = 1'b1;
          else                 MemWrite = 1'b1;
          if (mem_ready) state_d = (iclass == IC_LW) ? S_WB : S_IF;
        end
        S_WB: begin
          RegWrite = 1'b1;
          case (iclass)
            IC_RTYPE: begin GPRSel = GPR_RD; WDSel = WD_ALU; end
            IC_LW:    begin GPRSel = GPR_RT; WDSel = WD_MEM; end
            IC_JAL:   begin GPRSel = GPR_RA; WDSel = WD_PC;  end
            default:  begin GPRSel = GPR_RT; WDSel = WD_ALU; end
          endcase
          state_d = S_IF;
        end
        S_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          illegal = 1'b1;
`endif
          state_d = S_TRAP;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-phase expected outputs built from the
// instruction's phase list, checked every cycle, plus literal spot checks.
module tb_multicycle_ctrl;

  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5;
  localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_J = 6, K_JAL = 7, K_ILL = 8;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rw, mwr, mrd, ext, asrc;
    logic [2:0] aop;
    logic [1:0] npc, gsel, wsel;
    logic       ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = '0, Funct = '0;
  logic       Zero = 1'b0, mem_ready = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, EXTOp, ALUSrc;
  logic [2:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] state;
  logic       illegal;

  int    checks = 0, failures = 0;
  outs_t exp_o = '0;
  logic  exp_valid = 1'b0;
  string cur_tag = "init";
  outs_t snap [6];
  int    last_memc = 0;
  logic  tgl = 1'b0;

  multicycle_ctrl #(.ALUOP_W(3)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic outs_t dut_now();
    return {state, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, EXTOp, ALUSrc,
            ALUOp, NPCOp, GPRSel, WDSel, illegal};
  endfunction

  // What each phase of an instruction must drive, straight from the control table.
  function automatic outs_t model(int p, int k, logic [2:0] aop, logic z, logic mr);
    outs_t o = '0;
    o.st = 3'(p);
    case (p)
      P_IF: begin
        o.mrd = 1'b1;
        if (mr) begin o.irw = 1'b1; o.pcw = 1'b1; end
      end
      P_ID: if (k == K_J || k == K_JAL) begin o.pcw = 1'b1; o.npc = 2'b10; end
      P_EXE: begin
        o.aop  = aop;
        o.asrc = (k == K_ADDI || k == K_ORI || k == K_LW || k == K_SW);
        o.ext  = (k == K_ADDI || k == K_LW || k == K_SW);
        if (k == K_BEQ) begin o.pcw = z; o.npc = 2'b01; end
      end
      P_MEM: if (k == K_LW) o.mrd = 1'b1; else o.mwr = 1'b1;
      P_WB: begin
        o.rw   = 1'b1;
        o.gsel = (k == K_JAL) ? 2'b10 : (k == K_R) ? 2'b00 : 2'b01;
        o.wsel = (k == K_JAL) ? 2'b10 : (k == K_LW) ? 2'b01 : 2'b00;
      end
      P_TRAP: o.ill = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk({cur_tag, "_cycle"}, 32'(dut_now()), 32'(exp_o));
      chk({cur_tag, "_pcw_rw_excl"}, 32'(PCWrite & RegWrite), 32'd0);
    end
  end

  task automatic step(input int p, input int k, input logic [5:0] op, input logic [5:0] fn,
                      input logic [2:0] aop, input logic z, input logic mr, output outs_t s);
    @(posedge clk); #1;
    Op = op; Funct = fn; Zero = z; mem_ready = mr;
    exp_o = model(p, k, aop, z, mr);
    exp_valid = 1'b1;
    #1 s = dut_now();
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int k, input logic [2:0] aop, input logic z,
                           input int ifw, input int memw, input int lat);
    int    ph[$];
    int    nonif = 0, memc = 0, nw;
    logic  mr;
    outs_t s;
    cur_tag = tag;
    ph.push_back(P_IF);
    ph.push_back(P_ID);
    case (k)
      K_R, K_ADDI, K_ORI: begin ph.push_back(P_EXE); ph.push_back(P_WB); end
      K_LW:  begin ph.push_back(P_EXE); ph.push_back(P_MEM); ph.push_back(P_WB); end
      K_SW:  begin ph.push_back(P_EXE); ph.push_back(P_MEM); end
      K_BEQ: ph.push_back(P_EXE);
      K_JAL: ph.push_back(P_WB);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      K_ILL: for (int i = 0; i < 10; i++) ph.push_back(P_TRAP);
`endif
      default: ;
    endcase
    foreach (ph[i]) begin
      nw = (ph[i] == P_IF) ? ifw : (ph[i] == P_MEM) ? memw : 0;
      for (int w = 0; w <= nw; w++) begin
        if (ph[i] == P_IF || ph[i] == P_MEM) mr = (w == nw);
        else begin tgl = ~tgl; mr = tgl; end
        step(ph[i], k, op, fn, aop, z, mr, s);
        if (s.st != 3'd0) nonif++;
        if (s.st == 3'd3) memc++;
        snap[ph[i]] = s;
      end
    end
    chk({tag, "_latency"}, 32'(1 + nonif), 32'(lat));
    last_memc = memc;
  endtask

  task automatic do_reset(input int n);
    cur_tag = "reset";
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b1;
      exp_o = '0; exp_valid = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    exp_o = model(P_IF, K_R, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t s;
    do_reset(2);
    #1 chk("reset_release_state", 32'({state, illegal, RegWrite}), 32'd0);

    run_instr("add", 6'b000000, 6'b100000, K_R, 3'b001, 1'b0, 0, 0, 4);
    chk("add_exe_aluop", 32'(snap[P_EXE].aop), 32'(3'b001));
    chk("add_wb", 32'({snap[P_WB].rw, snap[P_WB].gsel, snap[P_WB].wsel}), 32'(5'b1_00_00));
    run_instr("sub",  6'b000000, 6'b100010, K_R, 3'b010, 1'b0, 0, 0, 4);
    run_instr("and",  6'b000000, 6'b100100, K_R, 3'b011, 1'b0, 0, 0, 4);
    run_instr("or",   6'b000000, 6'b100101, K_R, 3'b100, 1'b0, 0, 0, 4);
    run_instr("slt",  6'b000000, 6'b101010, K_R, 3'b101, 1'b0, 0, 0, 4);
    run_instr("sltu", 6'b000000, 6'b101011, K_R, 3'b110, 1'b0, 0, 0, 4);
    run_instr("sll",  6'b000000, 6'b000000, K_R, 3'b111, 1'b0, 0, 0, 4);
    run_instr("addu", 6'b000000, 6'b100001, K_R, 3'b001, 1'b0, 0, 0, 4);
    run_instr("subu", 6'b000000, 6'b100011, K_R, 3'b010, 1'b0, 0, 0, 4);
    run_instr("addi", 6'b001000, 6'b010101, K_ADDI, 3'b001, 1'b0, 0, 0, 4);
    run_instr("ori",  6'b001101, 6'b111000, K_ORI, 3'b100, 1'b0, 0, 0, 4);
    chk("ori_exe_src_ext", 32'({snap[P_EXE].asrc, snap[P_EXE].ext}), 32'(2'b10));
    run_instr("add_ifwait", 6'b000000, 6'b100000, K_R, 3'b001, 1'b0, 2, 0, 4);

    run_instr("lw", 6'b100011, 6'b000000, K_LW, 3'b001, 1'b0, 0, 3, 8);
    chk("lw_mem_cycles", 32'(last_memc), 32'd4);
    chk("lw_wb", 32'({snap[P_WB].rw, snap[P_WB].wsel, snap[P_WB].gsel}), 32'(5'b1_01_01));
    run_instr("sw", 6'b101011, 6'b000000, K_SW, 3'b001, 1'b0, 0, 0, 4);

    run_instr("beq_taken", 6'b000100, 6'b000000, K_BEQ, 3'b010, 1'b1, 0, 0, 3);
    chk("beq_taken_exe", 32'({snap[P_EXE].pcw, snap[P_EXE].npc}), 32'(3'b1_01));
    run_instr("beq_not", 6'b000100, 6'b000000, K_BEQ, 3'b010, 1'b0, 0, 0, 3);
    chk("beq_not_exe", 32'({snap[P_EXE].pcw, snap[P_EXE].npc}), 32'(3'b0_01));

    run_instr("j", 6'b000010, 6'b000000, K_J, 3'b000, 1'b0, 0, 0, 2);
    run_instr("jal", 6'b000011, 6'b000000, K_JAL, 3'b000, 1'b0, 0, 0, 3);
    chk("jal_id", 32'({snap[P_ID].pcw, snap[P_ID].npc}), 32'(3'b1_10));
    chk("jal_wb", 32'({snap[P_WB].rw, snap[P_WB].gsel, snap[P_WB].wsel}), 32'(5'b1_10_10));

    // Reset in the middle of a store's MEM phase.
    cur_tag = "sw_abort";
    step(P_IF,  K_SW, 6'b101011, 6'b0, 3'b001, 1'b0, 1'b1, s);
    step(P_ID,  K_SW, 6'b101011, 6'b0, 3'b001, 1'b0, 1'b0, s);
    step(P_EXE, K_SW, 6'b101011, 6'b0, 3'b001, 1'b0, 1'b1, s);
    step(P_MEM, K_SW, 6'b101011, 6'b0, 3'b001, 1'b0, 1'b0, s);
    chk("sw_abort_memwrite_before", 32'(s.mwr), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1 chk("sw_abort_now", 32'({state, MemWrite, RegWrite, MemRead}), 32'd0);
    do_reset(1);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    run_instr("illegal", 6'b111111, 6'b000000, K_ILL, 3'b000, 1'b0, 0, 0, 12);
    chk("trap_state", 32'({snap[P_TRAP].st, snap[P_TRAP].ill}), 32'(4'b101_1));
    do_reset(1);
    #1 chk("trap_cleared", 32'({state, illegal}), 32'd0);
`else
    run_instr("illegal", 6'b111111, 6'b000000, K_ILL, 3'b000, 1'b0, 0, 0, 2);
    chk("illegal_flag", 32'(snap[P_ID].ill), 32'd0);
`endif
    run_instr("add_after", 6'b000000, 6'b100000, K_R, 3'b001, 1'b0, 0, 0, 4);

    cur_tag = "idle";
    step(P_IF, K_R, 6'b0, 6'b0, 3'b000, 1'b0, 1'b0, s);
    @(negedge clk); #1;
    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
